// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Stalls IF..EX while busy and presents quotient/remainder with a one-cycle ready pulse.
module ex_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             stallreq,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             neg_q, neg_r;

  logic             accept, dvz, last;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] sub, rem_nx, quo_nx;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             a_neg, b_neg;

  assign accept = (state == IDLE) && start && !cancel;
  assign dvz    = (divisor == '0);
  assign last   = (state == BUSY) && (cnt == CW'(WIDTH-1));
  assign a_neg  = signed_op && dividend[WIDTH-1];
  assign b_neg  = signed_op && divisor[WIDTH-1];
  assign a_abs  = a_neg ? -dividend : dividend;
  assign b_abs  = b_neg ? -divisor  : divisor;

  // The shifted partial remainder needs one extra bit; when it reaches the
  // divisor the difference always fits back into WIDTH bits.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    ge      = (shifted >= {1'b0, dvs_q});
    sub     = shifted[WIDTH-1:0] - dvs_q;
    rem_nx  = ge ? sub : shifted[WIDTH-1:0];
    quo_nx  = {quo_q[WIDTH-2:0], ge};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = dvz ? DONE : BUSY;
      BUSY: if (last)   state_nx = DONE;
      DONE:             state_nx = IDLE;
      default:          state_nx = IDLE;
    endcase
    if (cancel) state_nx = IDLE;
  end

  assign stallreq = !cancel && (((state == IDLE) && start) || (state == BUSY));
  assign ready    = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state <= state_nx;
      if (cancel) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= '0;
        if (dvz) begin
          quotient  <= '1;
          remainder <= dividend;
        end else begin
          rem_q <= '0;
          quo_q <= a_abs;
          dvs_q <= b_abs;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
        end
      end else if (state == BUSY) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt   <= last ? '0 : cnt + CW'(1);
        // Sign fixup lands in the output registers on the edge into DONE.
        if (last) begin
          quotient  <= neg_q ? -quo_nx : quo_nx;
          remainder <= neg_r ? -rem_nx : rem_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: vector table for single divides plus
// hand-written cancel, reset and back-to-back sequences.
module tb_ex_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, signed_op, cancel;
  logic [W-1:0] dividend, divisor;
  logic         stallreq, ready;
  logic [W-1:0] quotient, remainder;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .cancel(cancel),
    .stallreq(stallreq), .ready(ready), .quotient(quotient), .remainder(remainder)
  );

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Start a divide, hold start until the ready cycle, then drop it.
  task automatic run_div(input vec_t v, input int idx);
    int  cyc;
    bit  got, stall_bad;
    step();
    start = 1'b1; signed_op = v.sgn; dividend = v.a; divisor = v.b;
    cyc = 0; got = 0; stall_bad = 0;
    while (cyc < 40) begin
      @(negedge clk);
      if (ready) begin
        got = 1;
        if (stallreq) stall_bad = 1;
        break;
      end
      if (!stallreq) stall_bad = 1;
      step();
      cyc++;
      // latched copies only: scramble the operand buses while busy
      dividend = $urandom; divisor = $urandom; signed_op = ~signed_op;
    end
    chk($sformatf("v%0d ready_seen", idx), W'(got), W'(1));
    chk($sformatf("v%0d latency", idx), W'(cyc), W'(v.lat));
    chk($sformatf("v%0d quotient", idx), quotient, v.q);
    chk($sformatf("v%0d remainder", idx), remainder, v.r);
    chk($sformatf("v%0d stallreq", idx), W'(stall_bad), W'(0));
    step();
    start = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d single_pulse", idx), W'(ready), W'(0));
  endtask

  initial begin
    int  cyc, t1, t2, npulse;
    bit  seen;
    logic [W-1:0] q1, r1, q2, r2;

    vecs.push_back('{0, 32'd100,        32'd7,          32'd14,         32'd2,          33});
    vecs.push_back('{1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   33});
    vecs.push_back('{1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          33});
    vecs.push_back('{1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          33});
    vecs.push_back('{0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1});
    vecs.push_back('{1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1});
    vecs.push_back('{0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          33});
    vecs.push_back('{0, 32'd3,          32'd10,         32'd0,          32'd3,          33});
    vecs.push_back('{1, 32'hFFFFFFF8,   32'hFFFFFFFD,   32'd2,          32'hFFFFFFFE,   33});
    vecs.push_back('{0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   33});
    vecs.push_back('{0, 32'd9,          32'd4,          32'd2,          32'd1,          33});

    rst = 1'b1; start = 1'b0; signed_op = 1'b0; cancel = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) step();
    @(negedge clk);
    chk("reset ready", W'(ready), W'(0));
    chk("reset quotient", quotient, '0);
    chk("reset remainder", remainder, '0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("idle stallreq", W'(stallreq), W'(0));

    foreach (vecs[i]) run_div(vecs[i], i);

    // Cancel in cycle 10 of DIVU 1000/3: prior result (9/4) must survive.
    step();
    start = 1'b1; signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    repeat (10) step();
    start = 1'b0; cancel = 1'b1;
    @(negedge clk);
    chk("cancel stallreq", W'(stallreq), W'(0));
    step();
    cancel = 1'b0;
    @(negedge clk);
    chk("post-cancel stallreq", W'(stallreq), W'(0));
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) seen = 1;
    end
    chk("cancel no ready", W'(seen), W'(0));
    chk("cancel q held", quotient, 32'd2);
    chk("cancel r held", remainder, 32'd1);

    // Back-to-back DIVU 9/4 then 20/6 with start held throughout.
    step();
    start = 1'b1; signed_op = 1'b0; dividend = 32'd9; divisor = 32'd4;
    t1 = -1; t2 = -1; npulse = 0; q1 = '0; r1 = '0; q2 = '0; r2 = '0;
    for (cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (ready) begin
        npulse++;
        if (t1 < 0) begin t1 = cyc; q1 = quotient; r1 = remainder; end
        else if (t2 < 0) begin t2 = cyc; q2 = quotient; r2 = remainder; end
      end
      step();
      if (t1 >= 0 && cyc == t1) begin dividend = 32'd20; divisor = 32'd6; end
      if (t2 >= 0) start = 1'b0;
    end
    chk("b2b first cycle", W'(t1), W'(33));
    chk("b2b spacing", W'(t2 - t1), W'(34));
    chk("b2b pulse count", W'(npulse), W'(2));
    chk("b2b q1", q1, 32'd2);
    chk("b2b r1", r1, 32'd1);
    chk("b2b q2", q2, 32'd3);
    chk("b2b r2", r2, 32'd2);

    // Reset mid-operation clears outputs and returns to idle.
    step();
    start = 1'b1; signed_op = 1'b1; dividend = 32'd77; divisor = 32'd5;
    repeat (5) step();
    start = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst quotient", quotient, '0);
    chk("midrst remainder", remainder, '0);
    chk("midrst stallreq", W'(stallreq), W'(0));
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) seen = 1;
    end
    chk("midrst no ready", W'(seen), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
